// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants and types for the seven-segment scan controller
package seven_seg_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    // A single digit still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// rtl/seven_seg_scan_ctrl_if.sv - load handshake and display drive bundle for the scan controller
interface seven_seg_scan_ctrl_if
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) ();

    logic                        enable;
    logic [BCD_W*NUM_DIGITS-1:0] digits_in;
    logic                        load;
    logic                        load_ack;
    logic [BCD_W-1:0]            bcd_out;
    logic [NUM_DIGITS-1:0]       digit_en_n;
    logic                        frame_done;

    modport master (
        output enable,
        output digits_in,
        output load,
        input  load_ack,
        input  bcd_out,
        input  digit_en_n,
        input  frame_done
    );

    modport slave (
        input  enable,
        input  digits_in,
        input  load,
        output load_ack,
        output bcd_out,
        output digit_en_n,
        output frame_done
    );

endinterface

// File: rtl/scan_slot_timer.sv
// rtl/scan_slot_timer.sv - per-slot cycle counter with digit index wrap
module scan_slot_timer
    import seven_seg_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    parameter  int TICK_DIV   = 50000,
    parameter  int BLANK_CYC  = 16,
    localparam int CW         = $clog2(TICK_DIV),
    localparam int IW         = idx_width(NUM_DIGITS)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          advance,
    output logic [IW-1:0] idx_nxt,
    output logic          in_blank,
    output logic          slot_end,
    output logic          frame_end
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [IW-1:0] idx_q;

    // in_blank and frame_end describe the coming cycle so the parent can
    // register its outputs; slot_end describes the current cycle.
    always_comb begin
        cnt_d   = cnt_q;
        idx_nxt = idx_q;
        if (clear) begin
            cnt_d   = '0;
            idx_nxt = '0;
        end else if (advance) begin
            if (cnt_q == CW'(TICK_DIV - 1)) begin
                cnt_d   = '0;
                idx_nxt = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        slot_end  = (cnt_q == CW'(TICK_DIV - 1));
        in_blank  = (cnt_d < CW'(BLANK_CYC));
        frame_end = (cnt_d == CW'(TICK_DIV - 1)) && (idx_nxt == IW'(NUM_DIGITS - 1));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_nxt;
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed common-anode digit scanner with frame-synchronous load
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000,
    parameter int BLANK_CYC  = 16,
    parameter int LZ_BLANK   = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    seven_seg_scan_ctrl_if.slave bus
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int DW = BCD_W * NUM_DIGITS;

    scan_state_t           state_q;
    scan_state_t           state_d;
    logic [DW-1:0]         shadow_q;
    logic [DW-1:0]         shadow_d;
    logic [DW-1:0]         pend_q;
    logic                  pend_flag_q;
    logic                  pend_nxt;
    logic                  xfer;
    logic [IW-1:0]         idx_nxt;
    logic                  in_blank;
    logic                  slot_end;
    logic                  frame_end;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  lead_zero;
    logic [BCD_W-1:0]      bcd_d;
    logic [BCD_W-1:0]      bcd_q;
    logic [NUM_DIGITS-1:0] en_n_d;
    logic [NUM_DIGITS-1:0] en_n_q;
    logic                  fd_d;
    logic                  fd_q;
    logic                  ack_d;
    logic                  ack_q;

    scan_slot_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .TICK_DIV   (TICK_DIV),
        .BLANK_CYC  (BLANK_CYC)
    ) u_timer (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (!bus.enable),
        .advance   (state_q != ST_OFF),
        .idx_nxt   (idx_nxt),
        .in_blank  (in_blank),
        .slot_end  (slot_end),
        .frame_end (frame_end)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:   state_d = ST_BLANK;
            ST_BLANK: if (!in_blank) state_d = ST_SHOW;
            ST_SHOW:  if (slot_end) state_d = ST_BLANK;
            default:  state_d = ST_OFF;
        endcase
        if (!bus.enable) begin
            state_d = ST_OFF;
        end
    end

    // The ack of the current cycle marks the transfer that happens at its end;
    // a LOAD landing on that same edge becomes the next pending value.
    always_comb begin
        xfer     = ack_q;
        shadow_d = xfer ? pend_q : shadow_q;
        pend_nxt = bus.load || (pend_flag_q && !xfer);
        fd_d     = (state_d == ST_SHOW) && frame_end;
        ack_d    = pend_nxt && (fd_d || (state_d == ST_OFF));
    end

    always_comb begin
        lz_mask   = '0;
        lead_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lead_zero  = lead_zero && (shadow_d[BCD_W*k +: BCD_W] == '0);
            lz_mask[k] = lead_zero && (k != 0) && (LZ_BLANK != 0);
        end
    end

    // BCD is presented during BLANK too, so the decoder has settled before the anode turns on.
    always_comb begin
        bcd_d  = BCD_BLANK;
        en_n_d = '1;
        if (state_d != ST_OFF) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_nxt == IW'(k)) begin
                    bcd_d = lz_mask[k] ? BCD_BLANK : shadow_d[BCD_W*k +: BCD_W];
                    if (state_d == ST_SHOW) begin
                        en_n_d[k] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_OFF;
            shadow_q    <= '0;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            bcd_q       <= BCD_BLANK;
            en_n_q      <= '1;
            fd_q        <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            if (bus.load) begin
                pend_q <= bus.digits_in;
            end
            pend_flag_q <= pend_nxt;
            bcd_q       <= bcd_d;
            en_n_q      <= en_n_d;
            fd_q        <= fd_d;
            ack_q       <= ack_d;
        end
    end

    assign bus.bcd_out    = bcd_q;
    assign bus.digit_en_n = en_n_q;
    assign bus.frame_done = fd_q;
    assign bus.load_ack   = ack_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - randomized and directed bench for seven_seg_scan_ctrl
module tb_seven_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int TD = 8;
    localparam int BC = 2;
    localparam int FR = N * TD;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(N)) ifc ();
    seven_seg_scan_ctrl_if #(.NUM_DIGITS(N)) ifz ();

    assign ifz.enable    = ifc.enable;
    assign ifz.digits_in = ifc.digits_in;
    assign ifz.load      = ifc.load;

    seven_seg_scan_ctrl #(.NUM_DIGITS(N), .TICK_DIV(TD), .BLANK_CYC(BC), .LZ_BLANK(1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifc.slave)
    );

    seven_seg_scan_ctrl #(.NUM_DIGITS(N), .TICK_DIV(TD), .BLANK_CYC(BC), .LZ_BLANK(0)) dut_nz (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifz.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: m_t counts cycles since the scan left OFF (-1 while dark).
    int          m_t;
    logic [15:0] m_sh, m_pend;
    bit          m_pflag, m_ack, m_fd;
    logic [3:0]  m_en, m_bcd, m_bcd_nz;

    function automatic logic [3:0] ref_digit(input logic [15:0] sh, input int idx, input bit lz);
        int top_nz = -1;
        logic [3:0] d;
        for (int k = 0; k < N; k++) if (((sh >> (4 * k)) & 16'hF) != 0) top_nz = k;
        d = 4'((sh >> (4 * idx)) & 16'hF);
        if (lz && idx > 0 && idx > top_nz) return 4'hF;
        return d;
    endfunction

    task automatic step();
        int pos, idx, c;
        @(posedge clk);
        if (!resetn) begin
            m_t = -1; m_sh = 16'h0; m_pend = 16'h0; m_pflag = 0; m_ack = 0;
        end else begin
            if (m_ack) m_sh = m_pend;
            if (ifc.load) begin
                m_pend = ifc.digits_in; m_pflag = 1;
            end else if (m_ack) begin
                m_pflag = 0;
            end
            m_t = ifc.enable ? m_t + 1 : -1;
        end
        if (m_t < 0) begin
            m_en = 4'hF; m_bcd = 4'hF; m_bcd_nz = 4'hF; m_fd = 0;
        end else begin
            pos = m_t % FR; idx = pos / TD; c = pos % TD;
            m_en     = (c < BC) ? 4'hF : ~(4'b0001 << idx);
            m_bcd    = ref_digit(m_sh, idx, 1'b1);
            m_bcd_nz = ref_digit(m_sh, idx, 1'b0);
            m_fd     = (idx == N - 1) && (c == TD - 1);
        end
        m_ack = resetn && m_pflag && (m_t < 0 || m_fd);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; ifc.enable = 1'b1; ifc.load = 1'b0; ifc.digits_in = 16'h0;
        repeat (3) begin
            step();
            n_checks++;
            if ({ifc.digit_en_n, ifc.bcd_out, ifz.bcd_out, ifc.frame_done, ifc.load_ack} !== {m_en, m_bcd, m_bcd_nz, m_fd, m_ack}) begin
                n_fail++;
                $display("FAIL reset_outs t=%0d got en=%b bcd=%h nz=%h fd=%b ack=%b exp en=%b bcd=%h nz=%h fd=%b ack=%b", m_t, ifc.digit_en_n, ifc.bcd_out, ifz.bcd_out, ifc.frame_done, ifc.load_ack, m_en, m_bcd, m_bcd_nz, m_fd, m_ack);
            end
            n_checks++;
            if (ifc.digit_en_n !== 4'b1111 || ifc.bcd_out !== 4'hF || ifc.frame_done !== 1'b0 || ifc.load_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_vals got en=%b bcd=%h fd=%b ack=%b exp en=1111 bcd=f fd=0 ack=0", ifc.digit_en_n, ifc.bcd_out, ifc.frame_done, ifc.load_ack);
            end
        end
        resetn = 1'b1;
    endtask

    task automatic test_scan();
        int last_fd = -1;
        int n_fd = 0;
        for (int i = 0; i < 2 * FR + 3; i++) begin
            step();
            n_checks++;
            if ({ifc.digit_en_n, ifc.bcd_out, ifz.bcd_out, ifc.frame_done, ifc.load_ack} !== {m_en, m_bcd, m_bcd_nz, m_fd, m_ack}) begin
                n_fail++;
                $display("FAIL scan_outs t=%0d got en=%b bcd=%h nz=%h fd=%b ack=%b exp en=%b bcd=%h nz=%h fd=%b ack=%b", m_t, ifc.digit_en_n, ifc.bcd_out, ifz.bcd_out, ifc.frame_done, ifc.load_ack, m_en, m_bcd, m_bcd_nz, m_fd, m_ack);
            end
            if (ifc.frame_done === 1'b1) begin
                n_fd++;
                n_checks++;
                if (last_fd >= 0 && i - last_fd != FR) begin
                    n_fail++;
                    $display("FAIL frame_period got %0d exp %0d", i - last_fd, FR);
                end
                last_fd = i;
            end
        end
        n_checks++;
        if (n_fd != 2) begin
            n_fail++;
            $display("FAIL frame_count got %0d exp 2", n_fd);
        end
    endtask

    task automatic test_load_display(input logic [15:0] v, input logic [15:0] exp_lz,
                                     input logic [15:0] exp_nz, input int start_pos);
        logic [3:0] sl [N];
        logic [3:0] sz [N];
        bit found = 0;
        for (int i = 0; i < 2 * FR && !(m_t >= 0 && m_t % FR == start_pos); i++) step();
        ifc.load = 1'b1; ifc.digits_in = v;
        step();
        ifc.load = 1'b0; ifc.digits_in = 16'($urandom);
        for (int i = 0; i < 2 * FR + 2 && !found; i++) begin
            step();
            n_checks++;
            if ({ifc.digit_en_n, ifc.bcd_out, ifz.bcd_out, ifc.frame_done, ifc.load_ack} !== {m_en, m_bcd, m_bcd_nz, m_fd, m_ack}) begin
                n_fail++;
                $display("FAIL load_outs t=%0d got en=%b bcd=%h nz=%h fd=%b ack=%b exp en=%b bcd=%h nz=%h fd=%b ack=%b", m_t, ifc.digit_en_n, ifc.bcd_out, ifz.bcd_out, ifc.frame_done, ifc.load_ack, m_en, m_bcd, m_bcd_nz, m_fd, m_ack);
            end
            if (ifc.load_ack === 1'b1) begin
                found = 1;
                n_checks++;
                if (ifc.frame_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ack_on_frame got fd=%b exp 1", ifc.frame_done);
                end
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL ack_timeout value=%h got no ack exp ack", v);
        end
        for (int k = 0; k < N; k++) begin sl[k] = 4'hx; sz[k] = 4'hx; end
        for (int i = 0; i < FR; i++) begin
            step();
            for (int k = 0; k < N; k++) if (ifc.digit_en_n[k] === 1'b0) begin
                sl[k] = ifc.bcd_out; sz[k] = ifz.bcd_out;
            end
        end
        n_checks++;
        if ({sl[3], sl[2], sl[1], sl[0]} !== exp_lz || {sz[3], sz[2], sz[1], sz[0]} !== exp_nz) begin
            n_fail++;
            $display("FAIL shown_%h got lz=%h nz=%h exp lz=%h nz=%h", v, {sl[3], sl[2], sl[1], sl[0]}, {sz[3], sz[2], sz[1], sz[0]}, exp_lz, exp_nz);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] sl [N];
        int acks = 0;
        bit found = 0;
        for (int i = 0; i < 2 * FR && !(m_t >= 0 && m_t % FR == 4); i++) step();
        for (int i = 0; i < 3; i++) begin
            ifc.load = (i != 1); ifc.digits_in = (i == 0) ? 16'h1111 : 16'h2222;
            step();
        end
        ifc.load = 1'b0;
        for (int i = 0; i < 2 * FR && !found; i++) begin
            step();
            n_checks++;
            if ({ifc.digit_en_n, ifc.bcd_out, ifz.bcd_out, ifc.frame_done, ifc.load_ack} !== {m_en, m_bcd, m_bcd_nz, m_fd, m_ack}) begin
                n_fail++;
                $display("FAIL b2b_outs t=%0d got en=%b bcd=%h nz=%h fd=%b ack=%b exp en=%b bcd=%h nz=%h fd=%b ack=%b", m_t, ifc.digit_en_n, ifc.bcd_out, ifz.bcd_out, ifc.frame_done, ifc.load_ack, m_en, m_bcd, m_bcd_nz, m_fd, m_ack);
            end
            if (ifc.load_ack === 1'b1) acks++;
            if (ifc.frame_done === 1'b1) found = 1;
        end
        n_checks++;
        if (!found || acks != 1 || ifc.load_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ack got frame=%0d acks=%0d ack_now=%b exp frame=1 acks=1 ack_now=1", found, acks, ifc.load_ack);
        end
        ifc.load = 1'b1; ifc.digits_in = 16'h3333;
        step();
        ifc.load = 1'b0;
        for (int f = 0; f < 2; f++) begin
            acks = 0;
            for (int k = 0; k < N; k++) sl[k] = 4'hx;
            for (int i = 0; i < FR - 1 + f; i++) begin
                step();
                n_checks++;
                if ({ifc.digit_en_n, ifc.bcd_out, ifz.bcd_out, ifc.frame_done, ifc.load_ack} !== {m_en, m_bcd, m_bcd_nz, m_fd, m_ack}) begin
                    n_fail++;
                    $display("FAIL b2b_outs t=%0d got en=%b bcd=%h nz=%h fd=%b ack=%b exp en=%b bcd=%h nz=%h fd=%b ack=%b", m_t, ifc.digit_en_n, ifc.bcd_out, ifz.bcd_out, ifc.frame_done, ifc.load_ack, m_en, m_bcd, m_bcd_nz, m_fd, m_ack);
                end
                if (ifc.load_ack === 1'b1) acks++;
                for (int k = 0; k < N; k++) if (ifc.digit_en_n[k] === 1'b0) sl[k] = ifc.bcd_out;
            end
            n_checks++;
            if ({sl[3], sl[2], sl[1], sl[0]} !== ((f == 0) ? 16'h2222 : 16'h3333) || acks != 1 - f) begin
                n_fail++;
                $display("FAIL b2b_frame%0d got shown=%h acks=%0d exp shown=%h acks=%0d", f, {sl[3], sl[2], sl[1], sl[0]}, acks, (f == 0) ? 16'h2222 : 16'h3333, 1 - f);
            end
        end
    endtask

    task automatic test_off_and_reset();
        for (int i = 0; i < 2 * FR && !(m_t >= 0 && m_t % FR == 12); i++) step();
        ifc.load = 1'b1; ifc.digits_in = 16'h9876;
        step();
        ifc.load = 1'b0; ifc.enable = 1'b0;
        step();
        n_checks++;
        if (ifc.digit_en_n !== 4'b1111 || ifc.bcd_out !== 4'hF || ifc.load_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL off_ack got en=%b bcd=%h ack=%b exp en=1111 bcd=f ack=1", ifc.digit_en_n, ifc.bcd_out, ifc.load_ack);
        end
        step();
        ifc.enable = 1'b1;
        for (int i = 0; i < BC + 1; i++) begin
            step();
            n_checks++;
            if ({ifc.digit_en_n, ifc.bcd_out, ifz.bcd_out, ifc.frame_done, ifc.load_ack} !== {m_en, m_bcd, m_bcd_nz, m_fd, m_ack}) begin
                n_fail++;
                $display("FAIL restart_outs t=%0d got en=%b bcd=%h nz=%h fd=%b ack=%b exp en=%b bcd=%h nz=%h fd=%b ack=%b", m_t, ifc.digit_en_n, ifc.bcd_out, ifz.bcd_out, ifc.frame_done, ifc.load_ack, m_en, m_bcd, m_bcd_nz, m_fd, m_ack);
            end
        end
        n_checks++;
        if (ifc.digit_en_n !== 4'b1110 || ifc.bcd_out !== 4'h6) begin
            n_fail++;
            $display("FAIL restart_idx0 got en=%b bcd=%h exp en=1110 bcd=6", ifc.digit_en_n, ifc.bcd_out);
        end
        repeat (13) step();
        ifc.load = 1'b1; ifc.digits_in = 16'h4444;
        step();
        ifc.load = 1'b0; resetn = 1'b0;
        step();
        resetn = 1'b1;
        n_checks++;
        if (ifc.digit_en_n !== 4'b1111 || ifc.bcd_out !== 4'hF || ifc.frame_done !== 1'b0 || ifc.load_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset got en=%b bcd=%h fd=%b ack=%b exp en=1111 bcd=f fd=0 ack=0", ifc.digit_en_n, ifc.bcd_out, ifc.frame_done, ifc.load_ack);
        end
        for (int i = 0; i < FR + 2; i++) begin
            step();
            n_checks++;
            if ({ifc.digit_en_n, ifc.bcd_out, ifz.bcd_out, ifc.frame_done, ifc.load_ack} !== {m_en, m_bcd, m_bcd_nz, m_fd, m_ack}) begin
                n_fail++;
                $display("FAIL post_reset_outs t=%0d got en=%b bcd=%h nz=%h fd=%b ack=%b exp en=%b bcd=%h nz=%h fd=%b ack=%b", m_t, ifc.digit_en_n, ifc.bcd_out, ifz.bcd_out, ifc.frame_done, ifc.load_ack, m_en, m_bcd, m_bcd_nz, m_fd, m_ack);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] mask;
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 4))
                0:       mask = 16'hFFFF;
                1:       mask = 16'h0FFF;
                2:       mask = 16'h00FF;
                3:       mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            ifc.load      = ($urandom_range(0, 7) == 0);
            ifc.digits_in = 16'($urandom) & mask;
            if ($urandom_range(0, 59) == 0) ifc.enable = ~ifc.enable;
            resetn = ($urandom_range(0, 249) != 0);
            step();
            n_checks++;
            if ({ifc.digit_en_n, ifc.bcd_out, ifz.bcd_out, ifc.frame_done, ifc.load_ack} !== {m_en, m_bcd, m_bcd_nz, m_fd, m_ack}) begin
                n_fail++;
                $display("FAIL random_outs t=%0d got en=%b bcd=%h nz=%h fd=%b ack=%b exp en=%b bcd=%h nz=%h fd=%b ack=%b", m_t, ifc.digit_en_n, ifc.bcd_out, ifz.bcd_out, ifc.frame_done, ifc.load_ack, m_en, m_bcd, m_bcd_nz, m_fd, m_ack);
            end
        end
        resetn = 1'b1; ifc.load = 1'b0; ifc.enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_display(16'h1234, 16'h1234, 16'h1234, 10);
        test_load_display(16'h0050, 16'hFF50, 16'h0050, 3);
        test_load_display(16'h0000, 16'hFFF0, 16'h0000, 20);
        test_load_display(16'hA000, 16'hA000, 16'hA000, 7);
        test_back_to_back();
        test_off_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
